// File: rtl/mutex_req_sequencer.sv
// mutex_req_sequencer: decodes per-core lock/unlock accesses into pulses towards a bank of mutexes and returns grants/handoff messages
//   clk_i, rst_ni                      : clock, asynchronous active-low reset
//   core_req_i/we_i/idx_i/wdata_i      : per-core request (we=1 unlock, we=0 lock), target mutex, unlock message
//   core_gnt_o/r_valid_o/r_rdata_o     : per-core accept, one-cycle response, response data
//   core_err_o                         : per-core sticky error (unexpected event, index out of range)
//   mutex_lock_req_o/unlock_req_o      : bit m*NB_CORES+c, single-cycle pulses from core c to mutex m
//   mutex_msg_wdata_o/msg_rdata_i      : per-mutex message written on unlock / current message register
//   mutex_event_i                      : bit m*NB_CORES+c, mutex m grants core c
module mutex_req_sequencer #(
  parameter int NB_CORES   = 8,
  parameter int NB_MUTEXES = 4,
  parameter int MSG_W      = 32,
  parameter int IDX_W      = (NB_MUTEXES > 1) ? $clog2(NB_MUTEXES) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NB_CORES-1:0]            core_req_i,
  input  logic [NB_CORES-1:0]            core_we_i,
  input  logic [NB_CORES*IDX_W-1:0]      core_idx_i,
  input  logic [NB_CORES*MSG_W-1:0]      core_wdata_i,
  output logic [NB_CORES-1:0]            core_gnt_o,
  output logic [NB_CORES-1:0]            core_r_valid_o,
  output logic [NB_CORES*MSG_W-1:0]      core_r_rdata_o,
  output logic [NB_CORES-1:0]            core_err_o,
  output logic [NB_MUTEXES*NB_CORES-1:0] mutex_lock_req_o,
  output logic [NB_MUTEXES*NB_CORES-1:0] mutex_unlock_req_o,
  output logic [NB_MUTEXES*MSG_W-1:0]    mutex_msg_wdata_o,
  input  logic [NB_MUTEXES*MSG_W-1:0]    mutex_msg_rdata_i,
  input  logic [NB_MUTEXES*NB_CORES-1:0] mutex_event_i
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, UNLOCK} state_e;
  state_e              state_q [NB_CORES];
  state_e              state_d [NB_CORES];
  logic [IDX_W-1:0]    idx_q   [NB_CORES];
  logic [IDX_W-1:0]    idx_d   [NB_CORES];
  logic [MSG_W-1:0]    wdata_q [NB_CORES];
  logic [MSG_W-1:0]    wdata_d [NB_CORES];
  logic [NB_CORES-1:0] err_q, err_d, gnt, hit, oor;
  // Unlocks of the same mutex in the same cycle: lowest core wins, losers keep requesting.
  // Gating with rst_ni keeps gnt low while reset is asserted.
  always_comb begin
    gnt = '0;
    oor = '0;
    for (int c = 0; c < NB_CORES; c++) begin
      oor[c] = int'(core_idx_i[c*IDX_W +: IDX_W]) >= NB_MUTEXES;
      gnt[c] = rst_ni && core_req_i[c] && state_q[c] == IDLE;
      for (int k = 0; k < c; k++)
        if (core_we_i[c] && core_req_i[k] && core_we_i[k] && state_q[k] == IDLE &&
            core_idx_i[k*IDX_W +: IDX_W] == core_idx_i[c*IDX_W +: IDX_W])
          gnt[c] = 1'b0;
    end
  end
  // Out-of-range accesses reuse UNLOCK: it answers with rdata 0 and, having no matching mutex, emits no pulse.
  always_comb begin
    hit   = '0;
    err_d = err_q;
    for (int c = 0; c < NB_CORES; c++) begin
      if (gnt[c] && oor[c]) err_d[c] = 1'b1;
      for (int m = 0; m < NB_MUTEXES; m++)
        if (mutex_event_i[m*NB_CORES + c]) begin
          if ((state_q[c] == ISSUE || state_q[c] == WAIT) && int'(idx_q[c]) == m) hit[c] = 1'b1;
          else err_d[c] = 1'b1;
        end
      state_d[c] = gnt[c] ? ((core_we_i[c] || oor[c]) ? UNLOCK : ISSUE)
                 : (state_q[c] == ISSUE || state_q[c] == WAIT) ? (hit[c] ? RESP : WAIT)
                 : IDLE;
      idx_d[c]   = gnt[c] ? core_idx_i[c*IDX_W +: IDX_W] : idx_q[c];
      wdata_d[c] = gnt[c] ? core_wdata_i[c*MSG_W +: MSG_W] : wdata_q[c];
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NB_CORES; c++) begin
        state_q[c] <= IDLE;
        idx_q[c]   <= '0;
        wdata_q[c] <= '0;
      end
      err_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end
  // Lock waiters read the message combinationally in RESP: the mutex has updated it by then.
  always_comb begin
    core_gnt_o         = gnt;
    core_err_o         = err_q;
    core_r_valid_o     = '0;
    core_r_rdata_o     = '0;
    mutex_lock_req_o   = '0;
    mutex_unlock_req_o = '0;
    mutex_msg_wdata_o  = '0;
    for (int c = 0; c < NB_CORES; c++) begin
      core_r_valid_o[c] = state_q[c] inside {RESP, UNLOCK};
      for (int m = 0; m < NB_MUTEXES; m++)
        if (int'(idx_q[c]) == m) begin
          mutex_lock_req_o[m*NB_CORES + c]   = state_q[c] == ISSUE;
          mutex_unlock_req_o[m*NB_CORES + c] = state_q[c] == UNLOCK;
          if (state_q[c] == RESP) core_r_rdata_o[c*MSG_W +: MSG_W] = mutex_msg_rdata_i[m*MSG_W +: MSG_W];
          if (state_q[c] == UNLOCK) mutex_msg_wdata_o[m*MSG_W +: MSG_W] |= wdata_q[c];
        end
    end
  end
endmodule

// File: tb/tb_mutex_req_sequencer.sv
// tb_mutex_req_sequencer: vector table plus multi-cycle sequences, responses checked against an expectation queue
module tb_mutex_req_sequencer;
  localparam int NC = 8, NM = 4, MW = 32, IW = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NC-1:0] req = '0, we = '0, gnt, rv, err;
  logic [NC*IW-1:0] idx = '0;
  logic [NC*MW-1:0] wdata = '0, rdata;
  logic [NM*NC-1:0] lreq, ureq, ev = '0;
  logic [NM*MW-1:0] mwd, mrd;
  logic [MW-1:0] msg_q [NM];
  logic [NC-1:0] req2 = '0, gnt2, rv2, err2;
  logic [NC*IW-1:0] idx2 = '0;
  logic [NC*MW-1:0] rdata2;
  logic [3*NC-1:0] lreq2, ureq2;
  logic [3*MW-1:0] mwd2;
  int n_tests = 0, n_fail = 0;
  typedef struct {int core; logic [MW-1:0] data;} exp_t;
  exp_t exp_q[$];
  typedef struct {int core; bit we; int idx; logic [MW-1:0] wdata; logic [MW-1:0] exp_rdata;} vec_t;
  vec_t vecs [10];

  always #5 clk = ~clk;

  mutex_req_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .core_req_i(req), .core_we_i(we), .core_idx_i(idx),
    .core_wdata_i(wdata), .core_gnt_o(gnt), .core_r_valid_o(rv), .core_r_rdata_o(rdata),
    .core_err_o(err), .mutex_lock_req_o(lreq), .mutex_unlock_req_o(ureq),
    .mutex_msg_wdata_o(mwd), .mutex_msg_rdata_i(mrd), .mutex_event_i(ev)
  );

  mutex_req_sequencer #(.NB_MUTEXES(3)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .core_req_i(req2), .core_we_i('0), .core_idx_i(idx2),
    .core_wdata_i('0), .core_gnt_o(gnt2), .core_r_valid_o(rv2), .core_r_rdata_o(rdata2),
    .core_err_o(err2), .mutex_lock_req_o(lreq2), .mutex_unlock_req_o(ureq2),
    .mutex_msg_wdata_o(mwd2), .mutex_msg_rdata_i('0), .mutex_event_i('0)
  );

  // Downstream mutex message registers: take the unlock message one cycle after the pulse.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) for (int m = 0; m < NM; m++) msg_q[m] <= '0;
    else for (int m = 0; m < NM; m++) if (|ureq[m*NC +: NC]) msg_q[m] <= mwd[m*MW +: MW];
  always_comb begin
    mrd = '0;
    for (int m = 0; m < NM; m++) mrd[m*MW +: MW] = msg_q[m];
  end

  always @(negedge clk)
    if (rst_n)
      for (int c = 0; c < NC; c++)
        if (rv[c]) begin
          int f;
          f = -1;
          for (int i = 0; i < exp_q.size(); i++) if (f < 0 && exp_q[i].core == c) f = i;
          n_tests++;
          if (f < 0) begin
            n_fail++;
            $display("FAIL resp_unexpected core %0d: got r_valid rdata %h, required no response", c, rdata[c*MW +: MW]);
          end else begin
            if (rdata[c*MW +: MW] !== exp_q[f].data) begin
              n_fail++;
              $display("FAIL resp_rdata core %0d: got %h required %h", c, rdata[c*MW +: MW], exp_q[f].data);
            end
            exp_q.delete(f);
          end
        end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start(int c, bit w, int m, logic [MW-1:0] d);
    req[c] = 1'b1;
    we[c] = w;
    idx[c*IW +: IW] = IW'(m);
    wdata[c*MW +: MW] = d;
  endtask
  task automatic unlock(int c, int m, logic [MW-1:0] d);
    start(c, 1'b1, m, d);
    exp_q.push_back('{c, '0});
    @(negedge clk);
    chk("unlock_gnt", 64'(gnt), 64'd1 << c);
    tick();
    req[c] = 1'b0;
    @(negedge clk);
    chk("unlock_pulse", 64'(ureq), 64'd1 << (m*NC + c));
    chk("unlock_msg_wdata", 64'(mwd[m*MW +: MW]), 64'(d));
    tick();
  endtask
  task automatic handoff(int o, int n, int m, logic [MW-1:0] d);
    unlock(o, m, d);
    ev[m*NC + n] = 1'b1;
    exp_q.push_back('{n, d});
    tick();
    ev = '0;
    tick();
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, 1, 32'h0, 32'h0};
    vecs[1] = '{0, 1'b1, 1, 32'hA5A5_0001, 32'h0};
    vecs[2] = '{2, 1'b0, 1, 32'h0, 32'hA5A5_0001};
    vecs[3] = '{2, 1'b1, 1, 32'h1234_5678, 32'h0};
    vecs[4] = '{5, 1'b0, 1, 32'h0, 32'h1234_5678};
    vecs[5] = '{5, 1'b1, 1, 32'h0, 32'h0};
    vecs[6] = '{7, 1'b0, 2, 32'h0, 32'h0};
    vecs[7] = '{7, 1'b1, 2, 32'hDEAD_BEEF, 32'h0};
    vecs[8] = '{6, 1'b0, 2, 32'h0, 32'hDEAD_BEEF};
    vecs[9] = '{6, 1'b1, 2, 32'h0000_0011, 32'h0};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({gnt, rv, err, |rdata, |lreq, |ureq, |mwd}), 64'd0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      start(vecs[i].core, vecs[i].we, vecs[i].idx, vecs[i].wdata);
      if (vecs[i].we) exp_q.push_back('{vecs[i].core, vecs[i].exp_rdata});
      @(negedge clk);
      chk("vec_gnt", 64'(gnt), 64'd1 << vecs[i].core);
      tick();
      req[vecs[i].core] = 1'b0;
      if (!vecs[i].we) begin
        ev[vecs[i].idx*NC + vecs[i].core] = 1'b1;
        exp_q.push_back('{vecs[i].core, vecs[i].exp_rdata});
      end
      @(negedge clk);
      chk("vec_lock_pulse", 64'(lreq), vecs[i].we ? 64'd0 : 64'd1 << (vecs[i].idx*NC + vecs[i].core));
      chk("vec_unlock_pulse", 64'(ureq), vecs[i].we ? 64'd1 << (vecs[i].idx*NC + vecs[i].core) : 64'd0);
      if (vecs[i].we) chk("vec_msg_wdata", 64'(mwd[vecs[i].idx*MW +: MW]), 64'(vecs[i].wdata));
      tick();
      ev = '0;
      tick();
      tick();
    end
    // core 3 waits on mutex 2 held by core 0, then receives core 0's handoff message
    start(0, 1'b0, 2, '0);
    @(negedge clk);
    chk("hold_gnt0", 64'(gnt), 64'd1);
    tick();
    req[0] = 1'b0;
    ev[2*NC + 0] = 1'b1;
    exp_q.push_back('{0, 32'h0000_0011});
    start(3, 1'b0, 2, '0);
    @(negedge clk);
    chk("wait_gnt3", 64'(gnt), 64'd1 << 3);
    tick();
    ev = '0;
    req[3] = 1'b0;
    @(negedge clk);
    chk("wait_lock_pulse3", 64'(lreq), 64'd1 << (2*NC + 3));
    tick();
    tick();
    @(negedge clk);
    chk("wait_no_pulse", 64'(lreq), 64'd0);
    tick();
    handoff(0, 3, 2, 32'hCAFE_0001);
    unlock(3, 2, 32'h0000_0033);
    // same-cycle unlocks of mutex 0 by cores 2 and 5
    start(2, 1'b1, 0, 32'h0000_2222);
    start(5, 1'b1, 0, 32'h0000_5555);
    exp_q.push_back('{2, '0});
    @(negedge clk);
    chk("arb_gnt_first", 64'(gnt), 64'd1 << 2);
    tick();
    req[2] = 1'b0;
    exp_q.push_back('{5, '0});
    @(negedge clk);
    chk("arb_gnt_second", 64'(gnt), 64'd1 << 5);
    chk("arb_pulse_first", 64'(ureq), 64'd1 << 2);
    chk("arb_wdata_first", 64'(mwd[0 +: MW]), 64'h2222);
    tick();
    req[5] = 1'b0;
    @(negedge clk);
    chk("arb_pulse_second", 64'(ureq), 64'd1 << 5);
    chk("arb_wdata_second", 64'(mwd[0 +: MW]), 64'h5555);
    tick();
    tick();
    // cores 1, 4, 6 lock mutex 3 together; the mutex serialises them
    start(1, 1'b0, 3, '0);
    start(4, 1'b0, 3, '0);
    start(6, 1'b0, 3, '0);
    @(negedge clk);
    chk("multi_gnt", 64'(gnt), 64'h52);
    tick();
    req = '0;
    ev[3*NC + 1] = 1'b1;
    exp_q.push_back('{1, '0});
    @(negedge clk);
    chk("multi_lock_pulses", 64'(lreq), (64'd1 << 25) | (64'd1 << 28) | (64'd1 << 30));
    tick();
    ev = '0;
    tick();
    handoff(1, 4, 3, 32'h1111_0003);
    handoff(4, 6, 3, 32'h4444_0003);
    unlock(6, 3, 32'h6666_0003);
    @(negedge clk);
    chk("no_err_so_far", 64'(err), 64'd0);
    tick();
    // spurious event to idle core 7
    ev[0*NC + 7] = 1'b1;
    tick();
    ev = '0;
    @(negedge clk);
    chk("spurious_err", 64'(err), 64'd1 << 7);
    chk("spurious_no_pulse", 64'({lreq, ureq}), 64'd0);
    tick();
    tick();
    @(negedge clk);
    chk("spurious_err_sticky", 64'(err), 64'd1 << 7);
    tick();
    // out-of-range index on the 3-mutex instance
    req2[7] = 1'b1;
    idx2[7*IW +: IW] = 2'd3;
    @(negedge clk);
    chk("oor_gnt", 64'(gnt2), 64'd1 << 7);
    tick();
    req2 = '0;
    @(negedge clk);
    chk("oor_rvalid", 64'(rv2), 64'd1 << 7);
    chk("oor_rdata", 64'(rdata2[7*MW +: MW]), 64'd0);
    chk("oor_no_pulse", 64'({lreq2, ureq2}), 64'd0);
    chk("oor_err", 64'(err2), 64'd1 << 7);
    tick();
    tick();
    @(negedge clk);
    chk("oor_err_sticky", 64'({rv2, err2}), 64'(8'h80));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    tick();
    // reset while core 3 waits on mutex 1
    start(3, 1'b0, 1, '0);
    @(negedge clk);
    chk("rst_seq_gnt", 64'(gnt), 64'd1 << 3);
    tick();
    req[3] = 1'b0;
    @(negedge clk);
    chk("rst_seq_pulse", 64'(lreq), 64'd1 << (NC + 3));
    tick();
    @(negedge clk);
    #2;
    req[5] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", 64'({gnt, rv, err, err2, |rdata, |lreq, |ureq, |mwd}), 64'd0);
    @(posedge clk);
    #1;
    req[5] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ev[NC + 3] = 1'b1;
    tick();
    ev = '0;
    @(negedge clk);
    chk("post_rst_err", 64'(err), 64'd1 << 3);
    chk("post_rst_quiet", 64'({rv, lreq, ureq}), 64'd0);
    tick();
    @(negedge clk);
    chk("post_rst_no_resp", 64'({rv, lreq}), 64'd0);
    chk("queue_empty_end", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mutex_req_sequencer.md
Name: mutex_req_sequencer

Overview:
Front-end controller between NB_CORES core-side request ports and a bank of NB_MUTEXES hardware mutex units, which sit downstream. It decodes each core's lock or unlock access and arbitrates simultaneous unlocks of the same mutex. It emits single-cycle lock/unlock pulses and holds a core's lock response until the mutex grants it. The granted core then receives the handoff message left by the previous owner.

Parameters:
NB_CORES, 8, number of core request ports
NB_MUTEXES, 4, number of downstream mutex units
MSG_W, 32, mutex message width
IDX_W, $clog2(NB_MUTEXES) (min 1), mutex index width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
core_req_i  in  NB_CORES  request valid per core
core_we_i  in  NB_CORES  1 = unlock (write), 0 = lock (read)
core_idx_i  in  NB_CORES*IDX_W  target mutex index; core c at [c*IDX_W +: IDX_W]
core_wdata_i  in  NB_CORES*MSG_W  unlock message
core_gnt_o  out  NB_CORES  request accepted this cycle
core_r_valid_o  out  NB_CORES  response valid, one-cycle pulse
core_r_rdata_o  out  NB_CORES*MSG_W  response data
core_err_o  out  NB_CORES  sticky: unexpected event or out-of-range index
mutex_lock_req_o  out  NB_MUTEXES*NB_CORES  bit m*NB_CORES+c: lock pulse to mutex m from core c
mutex_unlock_req_o  out  NB_MUTEXES*NB_CORES  same layout, unlock pulse
mutex_msg_wdata_o  out  NB_MUTEXES*MSG_W  message to mutex m
mutex_msg_rdata_i  in  NB_MUTEXES*MSG_W  current message register of mutex m
mutex_event_i  in  NB_MUTEXES*NB_CORES  grant event from mutex m to core c

Behaviour:
- Reset values:
  - All outputs 0.
  - All per-core FSMs IDLE.
  - Captured index, message and error registers 0.
- Per-core FSM states: IDLE, ISSUE, WAIT, RESP, UNLOCK.
- IDLE, lock (req=1, we=0):
  - gnt=1 combinationally the same cycle T.
  - Register idx; go to ISSUE.
- ISSUE (T+1):
  - Assert mutex_lock_req_o[idx*NB_CORES+c] for exactly one cycle.
  - If mutex_event_i[idx*NB_CORES+c]=1 in this cycle, go to RESP; else go to WAIT.
- WAIT:
  - No pulses.
  - On mutex_event_i[idx*NB_CORES+c], go to RESP.
- RESP:
  - r_valid=1 for one cycle with r_rdata = mutex_msg_rdata_i[idx], sampled combinationally this cycle. This is the message written by the unlocking owner, because the mutex updates its message one cycle after the unlock pulse.
  - Then go to IDLE.
- IDLE, unlock (req=1, we=1):
  - Arbitrate among cores requesting unlock of the same idx in the same cycle. The lowest core index wins and gets gnt=1. Losers get gnt=0, stay IDLE and retry with requests held.
  - Winner registers idx and wdata; go to UNLOCK.
- UNLOCK (T+1):
  - Assert mutex_unlock_req_o[idx*NB_CORES+c] for one cycle.
  - Drive mutex_msg_wdata_o[idx] = registered wdata.
  - r_valid=1, r_rdata=0.
  - Then go to IDLE.
- mutex_msg_wdata_o[m] is the data of the core in UNLOCK targeting m, else 0. At most one such core exists per mutex per cycle, guaranteed by arbitration.
- Lock requests are never arbitrated: pulses from several cores to one mutex in the same cycle are forwarded unchanged, and the mutex serialises them.
- gnt=0 in every state other than IDLE. A core issues a new request only after r_valid.
- Index out of range (idx >= NB_MUTEXES):
  - Grant, no pulse.
  - r_valid next cycle with r_rdata=0.
  - Set err.
- Event for core c while not in ISSUE/WAIT, or for a mutex other than the registered idx: ignored; set err.
- err clears only on reset.
- Reset mid-operation: all FSMs return to IDLE immediately, pending lock waiters are dropped, and no pulses are emitted after reset deasserts.
- Latency:
  - Uncontended lock: req→r_valid = 2 cycles (grant T, pulse/event T+1, r_valid T+2).
  - Unlock: r_valid at T+1.

Test Plan:
- Core 0 locks free mutex 1 at T → gnt T, lock pulse bit 1*NB_CORES+0 at T+1, event same cycle, r_valid T+2, rdata=0 after reset.
- Core 0 holds mutex 2; core 3 locks mutex 2 → core 3 in WAIT. Core 0 unlocks with 0xCAFE0001 → core 3 r_valid two cycles after core 0's pulse with rdata 0xCAFE0001.
- Cores 2 and 5 unlock mutex 0 in the same cycle → only core 2 gnt. Core 5 granted the next cycle, two successive unlock pulses, msg_wdata follows each core.
- Cores 1, 4, 6 lock mutex 3 simultaneously while unlocked → all pulses the same cycle. Responses in event order driven by the mutex (core 1 first), each after the previous owner unlocks.
- Spurious event to idle core 7, and core 7 accessing idx=NB_MUTEXES (when not a power of two) → err_o[7]=1 sticky, r_rdata=0, no pulses.
- Assert rst_ni low while core 3 is in WAIT → all outputs 0 asynchronously. After release, a later event for core 3 only sets err, with no r_valid.
